mult_ctrl_fsm: RTL
==================

// Module: mult_ctrl_fsm
// PURPOSE
//   Control FSM for the shift-add signed multiplier datapath (X/A/B registers, 9-bit adder).
//   Sequences one multiply per Run: clear XA, then WIDTH add/sub-then-shift steps driven by M (= B[0]),
//   then hold the result. Steps 0..WIDTH-2 add. The final step subtracts (two's-complement multiplier).
//   Sits between the debounced/synchronised board inputs and the register/adder enables in Processor.
// PARAMETERS
//   WIDTH  8  operand width; number of add/shift steps per multiply (>=2)
// PORTS
//   Clk         in   1  system clock, all state on rising edge
//   Reset_n     in   1  asynchronous, active-low reset
//   Run         in   1  start request, synchronised/debounced level
//   Load_Clear  in   1  synchronised level: clear XA and load B from switches
//   M           in   1  current multiplier LSB (B[0])
//   Clr_XA      out  1  clear X and A registers this cycle
//   Ld_B        out  1  load B from switches this cycle
//   Add         out  1  load A/X with A + SW (sign-extended to 9 bits)
//   Sub         out  1  load A/X with A - SW (sign-extended to 9 bits)
//   Shift       out  1  arithmetic right shift of X:A:B by one
//   Done        out  1  multiply complete, result valid in X:A:B
// BEHAVIOUR
//   - States: IDLE, CLEAR, ADD, SHIFT, HOLD. Step counter cnt, $clog2(WIDTH) bits.
//   - Reset (async, Reset_n=0): state=IDLE, cnt=0. Every output is 0 immediately because outputs decode from state.
//   - IDLE: Run=1 -> CLEAR. Load_Clear=1 -> Clr_XA=1 and Ld_B=1 combinationally. Run has priority over Load_Clear:
//     - if both are high, Clr_XA/Ld_B still pulse this cycle and the FSM moves to CLEAR.
//   - CLEAR: Clr_XA=1 for 1 cycle, cnt<=0 -> ADD.
//   - ADD: Add = M & (cnt != WIDTH-1); Sub = M & (cnt == WIDTH-1). Go to SHIFT.
//   - SHIFT: Shift=1. If cnt==WIDTH-1 -> HOLD, else cnt<=cnt+1 -> ADD.
//   - HOLD: Done=1. Load_Clear handled as in IDLE. Run=0 -> IDLE.
//     - Run still high: stay in HOLD. No retrigger until Run is released.
//   - Latency: Run seen in IDLE at edge t -> Done first high after edge t+1+2*WIDTH (17 cycles at WIDTH=8).
//   - Run or Load_Clear changing in CLEAR/ADD/SHIFT: ignored; Clr_XA/Ld_B are held 0 during compute.
//   - M is sampled only in ADD. At most one of Add/Sub/Shift/Clr_XA (from CLEAR) is high per cycle.
//   - Reset mid-multiply: abort to IDLE. Datapath contents are the datapath's concern.
//   - cnt never wraps; its terminal value is WIDTH-1.
// CONFIGURATION
//   MULT_CTRL_SKIP_ZERO_EN defined:
//     - ADD with M=0 is skipped: SHIFT goes straight to SHIFT (cnt++).
//     - CLEAR also enters SHIFT directly when M=0.
//     - Latency becomes 1 + WIDTH + popcount(B). Done timing depends on operand.
//   Undefined: fixed 2*WIDTH+1 cycle sequence as above. The ADD state is visited with Add=Sub=0 when M=0.
// STRUCTURE
//   - Package mult_ctrl_pkg: typedef enum logic [2:0] state_t {IDLE,CLEAR,ADD,SHIFT,HOLD}; localparam STEP_W helper.
//   - No sub-module: two-process FSM plus inline counter.
//   - Outputs are pure decode of state/cnt/M/Load_Clear. No output registers.
// TESTING
//   1. Reset_n=0 mid-SHIFT at cnt=3 -> state IDLE at once, all outputs 0, cnt=0 after release.
//   2. Run pulse, M stream from B=0xC5 (LSB first: 1,0,1,0,0,0,1,1):
//      - Add in steps 0, 2, 6; Sub in step 7; 8 Shift pulses.
//      - Done at cycle 17; with SW=0x07 the datapath reads X=1, A=0xFE, B=0x63.
//   3. Run held high through HOLD for 10 cycles -> Done stays 1, no second CLEAR; Run low -> IDLE next edge.
//   4. Load_Clear=1 during ADD/SHIFT -> Clr_XA=Ld_B=0.
//      - Load_Clear=1 in HOLD -> Clr_XA=Ld_B=1 while asserted, Done stays 1.
//   5. M=0 every step (B=0x00) -> Add=Sub=0 throughout, 8 Shifts, Done at cycle 17.
//      - With MULT_CTRL_SKIP_ZERO_EN: Done at cycle 9.
//   6. Run and Load_Clear both high in IDLE -> single Clr_XA/Ld_B pulse, then CLEAR, normal sequence.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier control FSM.
// Optional MULT_CTRL_SKIP_ZERO_EN skips ADD steps whose multiplier bit is 0.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  function automatic int step_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Board-input / datapath-enable bundle between controller and Processor.
// Optional MULT_CTRL_SKIP_ZERO_EN does not change this bundle.
interface mult_ctrl_if;

  logic Run;
  logic Load_Clear;
  logic M;
  logic Clr_XA;
  logic Ld_B;
  logic Add;
  logic Sub;
  logic Shift;
  logic Done;

  modport master (
    output Run, Load_Clear, M,
    input  Clr_XA, Ld_B, Add, Sub, Shift, Done
  );

  modport slave (
    input  Run, Load_Clear, M,
    output Clr_XA, Ld_B, Add, Sub, Shift, Done
  );

endinterface

// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the signed shift-add multiplier (WIDTH steps per Run).
// Define MULT_CTRL_SKIP_ZERO_EN to bypass ADD when the multiplier bit is 0.
module mult_ctrl_fsm
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  mult_ctrl_if.slave bus
);

  localparam int CW = step_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last;
  logic          w_skip;

  assign w_last = (r_cnt == LAST);

`ifdef MULT_CTRL_SKIP_ZERO_EN
  assign w_skip = ~bus.M;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    bus.Clr_XA  = 1'b0;
    bus.Ld_B    = 1'b0;
    bus.Add     = 1'b0;
    bus.Sub     = 1'b0;
    bus.Shift   = 1'b0;
    bus.Done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.Clr_XA = bus.Load_Clear;
        bus.Ld_B   = bus.Load_Clear;
        if (bus.Run) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        bus.Clr_XA  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = w_skip ? SHIFT : ADD;
      end
      ADD: begin
        // final step subtracts: MSB of a two's-complement multiplier is negative
        bus.Add     = bus.M & ~w_last;
        bus.Sub     = bus.M & w_last;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.Shift = 1'b1;
        if (w_last) begin
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = w_skip ? SHIFT : ADD;
        end
      end
      HOLD: begin
        bus.Done   = 1'b1;
        bus.Clr_XA = bus.Load_Clear;
        bus.Ld_B   = bus.Load_Clear;
        if (!bus.Run) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
